// File: rtl/book_pkg.sv
// Shared defaults, side encoding and reader FSM states for the order-book
// reader (book_reader, book_best_cmp).
package book_pkg;

  localparam int BOOK_ROWS    = 10;
  localparam int BOOK_STOCKS  = 4;
  localparam int BOOK_PRICE_W = 32;
  localparam int BOOK_QTY_W   = 32;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/book_best_cmp.sv
// Per-side best-price accumulator: keeps the best price seen, its quantity
// and a found flag. PICK_MAX=1 tracks the highest price (bid side),
// PICK_MAX=0 tracks the lowest price (ask side). Only a strictly better
// price replaces the held one, so the earliest row wins a tie.
// Ports: clk, reset_n (sync, active-low), clear, en, price, qty in;
//        best, best_qty, found out.
module book_best_cmp
  import book_pkg::*;
#(
  parameter int PRICE_W  = BOOK_PRICE_W,
  parameter int QTY_W    = BOOK_QTY_W,
  parameter bit PICK_MAX = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  input  logic [PRICE_W-1:0] price,
  input  logic [QTY_W-1:0]   qty,
  output logic [PRICE_W-1:0] best,
  output logic [QTY_W-1:0]   best_qty,
  output logic               found
);

  logic better;

  always_comb begin
    better = 1'b0;
    if (PICK_MAX) better = (price > best);
    else          better = (price < best);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      best     <= '0;
      best_qty <= '0;
      found    <= 1'b0;
    end else if (clear) begin
      best     <= '0;
      best_qty <= '0;
      found    <= 1'b0;
    end else if (en && (!found || better)) begin
      best     <= price;
      best_qty <= qty;
      found    <= 1'b1;
    end
  end

endmodule

// File: rtl/book_reader.sv
// Order-book top-of-book reader: on a query, scans all ROWS entries of one
// stock through a one-cycle-latency read port and returns best bid/ask.
// Ports: clk, reset_n (sync, active-low); query_valid/ready, query_stock;
//        rd_en, rd_stock, rd_row out; rd_entry_valid, rd_side, rd_price,
//        rd_qty in; result_valid/ready; best_bid, best_ask, bid_qty,
//        ask_qty, bid_found, ask_found, result_err out.
// Option: define BOOK_READER_SPREAD_EN to add the spread output.
module book_reader
  import book_pkg::*;
#(
  parameter int ROWS    = BOOK_ROWS,
  parameter int STOCKS  = BOOK_STOCKS,
  parameter int PRICE_W = BOOK_PRICE_W,
  parameter int QTY_W   = BOOK_QTY_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    query_valid,
  output logic                    query_ready,
  input  logic [1:0]              query_stock,
  output logic                    rd_en,
  output logic [1:0]              rd_stock,
  output logic [$clog2(ROWS)-1:0] rd_row,
  input  logic                    rd_entry_valid,
  input  logic                    rd_side,
  input  logic [PRICE_W-1:0]      rd_price,
  input  logic [QTY_W-1:0]        rd_qty,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [PRICE_W-1:0]      best_bid,
  output logic [PRICE_W-1:0]      best_ask,
  output logic [QTY_W-1:0]        bid_qty,
  output logic [QTY_W-1:0]        ask_qty,
  output logic                    bid_found,
  output logic                    ask_found,
  output logic                    result_err
`ifdef BOOK_READER_SPREAD_EN
  ,
  output logic [PRICE_W-1:0]      spread
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

  rd_state_e      state, state_n;
  logic [1:0]     stock;
  logic [RW-1:0]  row;
  logic           eval;
  logic           err;
  logic           accept;
  logic           bad;
  logic           row_ok;
  logic           bid_en;
  logic           ask_en;

  assign accept = (state == ST_IDLE) && query_valid;
  assign bad    = int'(query_stock) >= STOCKS;

  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (query_valid) state_n = bad ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        rd_en = 1'b1;
        if (row == LAST) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_n = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // eval marks the cycle in which the row requested last cycle is on the bus
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      stock <= '0;
      row   <= '0;
      eval  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      eval  <= rd_en;
      if (accept) begin
        stock <= query_stock;
        err   <= bad;
        row   <= '0;
      end else if (state == ST_SCAN) begin
        row <= (row == LAST) ? '0 : row + RW'(1);
      end
    end
  end

  assign row_ok = eval && rd_entry_valid && (rd_qty != '0);
  assign bid_en = row_ok && (rd_side == SIDE_BUY);
  assign ask_en = row_ok && (rd_side == SIDE_SELL);

  book_best_cmp #(
    .PRICE_W  (PRICE_W),
    .QTY_W    (QTY_W),
    .PICK_MAX (1'b1)
  ) u_bid (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .en       (bid_en),
    .price    (rd_price),
    .qty      (rd_qty),
    .best     (best_bid),
    .best_qty (bid_qty),
    .found    (bid_found)
  );

  book_best_cmp #(
    .PRICE_W  (PRICE_W),
    .QTY_W    (QTY_W),
    .PICK_MAX (1'b0)
  ) u_ask (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .en       (ask_en),
    .price    (rd_price),
    .qty      (rd_qty),
    .best     (best_ask),
    .best_qty (ask_qty),
    .found    (ask_found)
  );

  assign query_ready  = (state == ST_IDLE);
  assign result_valid = (state == ST_DONE);
  assign result_err   = err;
  assign rd_stock     = stock;
  assign rd_row       = row;

`ifdef BOOK_READER_SPREAD_EN
  // Derived from the registered result, so it is frozen with it in DONE;
  // a crossed or one-sided book reports zero.
  assign spread = (bid_found && ask_found && (best_ask > best_bid))
                ? best_ask - best_bid : '0;
`endif

endmodule

// File: tb/tb_book_reader.sv
// Self-checking bench for book_reader: directed top-of-book scenarios,
// reset/abort, stall/ignore and randomized books against a reference model.
module tb_book_reader;

  localparam int ROWS   = 10;
  localparam int STOCKS = 3;
  localparam int PW     = 32;
  localparam int QW     = 32;
`ifdef BOOK_READER_SPREAD_EN
  localparam int SW = 3 + 3*PW + 2*QW;
`else
  localparam int SW = 3 + 2*PW + 2*QW;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          query_valid = 1'b0;
  logic          query_ready;
  logic [1:0]    query_stock = '0;
  logic          rd_en;
  logic [1:0]    rd_stock;
  logic [3:0]    rd_row;
  logic          rd_entry_valid = 1'b0;
  logic          rd_side = 1'b0;
  logic [PW-1:0] rd_price = '0;
  logic [QW-1:0] rd_qty = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [PW-1:0] best_bid, best_ask;
  logic [QW-1:0] bid_qty, ask_qty;
  logic          bid_found, ask_found, result_err;
`ifdef BOOK_READER_SPREAD_EN
  logic [PW-1:0] spread;
`endif

  always #5 clk = ~clk;

  book_reader #(
    .ROWS(ROWS), .STOCKS(STOCKS), .PRICE_W(PW), .QTY_W(QW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .query_valid(query_valid), .query_ready(query_ready),
    .query_stock(query_stock),
    .rd_en(rd_en), .rd_stock(rd_stock), .rd_row(rd_row),
    .rd_entry_valid(rd_entry_valid), .rd_side(rd_side),
    .rd_price(rd_price), .rd_qty(rd_qty),
    .result_valid(result_valid), .result_ready(result_ready),
    .best_bid(best_bid), .best_ask(best_ask),
    .bid_qty(bid_qty), .ask_qty(ask_qty),
    .bid_found(bid_found), .ask_found(ask_found),
    .result_err(result_err)
`ifdef BOOK_READER_SPREAD_EN
    , .spread(spread)
`endif
  );

  typedef struct {
    bit            v;
    bit            side;
    logic [PW-1:0] price;
    logic [QW-1:0] qty;
  } row_t;

  row_t book [STOCKS][ROWS];

  int n_cmp = 0;
  int n_bad = 0;
  logic [SW-1:0] cap;

  // Book memory: answers one cycle after rd_en, junk otherwise
  row_t rr;
  always @(posedge clk) begin
    if (rd_en && int'(rd_stock) < STOCKS && int'(rd_row) < ROWS) begin
      rr = book[int'(rd_stock)][int'(rd_row)];
      rd_entry_valid <= rr.v;
      rd_side        <= rr.side;
      rd_price       <= rr.price;
      rd_qty         <= rr.qty;
    end else begin
      rd_entry_valid <= 1'($urandom_range(0, 1));
      rd_side        <= 1'($urandom_range(0, 1));
      rd_price       <= $urandom;
      rd_qty         <= $urandom;
    end
  end

  function automatic logic [SW-1:0] snap();
    return {bid_found, ask_found, result_err,
            best_bid, bid_qty, best_ask, ask_qty
`ifdef BOOK_READER_SPREAD_EN
            , spread
`endif
           };
  endfunction

  // Reference: best bid = max over live buy rows, best ask = min over live
  // sell rows; quantity taken from the first row holding that price.
  function automatic logic [SW-1:0] ref_vec(input int stk);
    logic [PW-1:0] eb, ea, sp;
    logic [QW-1:0] bq, aq;
    logic [PW-1:0] bp[$];
    logic [PW-1:0] ap[$];
    logic [PW-1:0] t[$];
    bit bf, af, er, gb, ga;
    eb = '0; ea = '0; sp = '0; bq = '0; aq = '0;
    bf = 0; af = 0; er = 0; gb = 0; ga = 0;
    if (stk >= STOCKS) begin
      er = 1;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (book[stk][r].v && book[stk][r].qty != '0) begin
          if (book[stk][r].side) bp.push_back(book[stk][r].price);
          else                   ap.push_back(book[stk][r].price);
        end
      end
      if (bp.size() > 0) begin
        bf = 1; t = bp.max(); eb = t[0];
      end
      if (ap.size() > 0) begin
        af = 1; t = ap.min(); ea = t[0];
      end
      for (int r = 0; r < ROWS; r++) begin
        if (book[stk][r].v && book[stk][r].qty != '0) begin
          if (book[stk][r].side && bf && !gb &&
              book[stk][r].price == eb) begin
            bq = book[stk][r].qty; gb = 1;
          end
          if (!book[stk][r].side && af && !ga &&
              book[stk][r].price == ea) begin
            aq = book[stk][r].qty; ga = 1;
          end
        end
      end
      if (bf && af && ea > eb) sp = ea - eb;
    end
    return {bf, af, er, eb, bq, ea, aq
`ifdef BOOK_READER_SPREAD_EN
            , sp
`endif
           };
  endfunction

  function automatic void clear_book(input int s);
    for (int r = 0; r < ROWS; r++) begin
      book[s][r].v     = 0;
      book[s][r].side  = 1'($urandom_range(0, 1));
      book[s][r].price = $urandom;
      book[s][r].qty   = $urandom;
    end
  endfunction

  function automatic void set_row(input int s, input int r, input bit sd,
                                  input int p, input int q);
    book[s][r].v     = 1;
    book[s][r].side  = sd;
    book[s][r].price = PW'(p);
    book[s][r].qty   = QW'(q);
  endfunction

  // Issues one query, records timing, captures the result into cap,
  // holds result_ready low for hold cycles, then completes the handshake.
  task automatic run_query(input int stk, input int hold, input bit spam,
                           output int rd_cnt, output bit seq_ok,
                           output int valid_at, output bit qr_ok,
                           output bit stable_ok);
    rd_cnt = 0; seq_ok = 1; valid_at = -1; qr_ok = 1; stable_ok = 1;
    @(negedge clk);
    query_valid = 1'b1;
    query_stock = 2'(stk);
    result_ready = 1'b0;
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    for (int n = 1; n <= 40 && valid_at < 0; n++) begin
      @(negedge clk);
      if (query_ready) qr_ok = 0;
      if (rd_en) begin
        rd_cnt++;
        if (int'(rd_row) != n - 1 || int'(rd_stock) != stk || n > ROWS)
          seq_ok = 0;
      end
      if (result_valid) begin
        valid_at = n;
        query_valid = 1'b0;
      end else if (spam) begin
        query_valid = 1'b1;
        query_stock = 2'($urandom_range(0, 3));
      end
    end
    query_valid = 1'b0;
    cap = snap();
    if (valid_at < 0) begin
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (snap() !== cap || !result_valid || query_ready || rd_en)
        stable_ok = 0;
    end
    @(negedge clk);
    if (snap() !== cap || !result_valid) stable_ok = 0;
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({query_ready, rd_en, rd_stock, rd_row, result_valid} !==
        {1'b1, 1'b0, 2'b0, 4'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b qr=1 rd_en/stock/row/rv=0 expected",
               {query_ready, rd_en, rd_stock, rd_row, result_valid});
    end
    n_cmp++;
    if (snap() !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", snap());
    end
    reset_n = 1'b1;
  endtask

  task automatic test_top_of_book();
    int c, va; bit sq, qo, so;
    logic [SW-1:0] e;
    clear_book(1);
    set_row(1, 0, 1, 100, 5);
    set_row(1, 1, 1, 105, 7);
    set_row(1, 2, 1, 103, 9);
    set_row(1, 3, 0, 110, 1);
    set_row(1, 4, 0, 108, 2);
    e = {1'b1, 1'b1, 1'b0, 32'd105, 32'd7, 32'd108, 32'd2
`ifdef BOOK_READER_SPREAD_EN
         , 32'd3
`endif
        };
    run_query(1, 0, 0, c, sq, va, qo, so);
    n_cmp++;
    if (cap !== e) begin
      n_bad++;
      $display("FAIL tob_result: got %h expected %h", cap, e);
    end
    n_cmp++;
    if (va !== ROWS + 2) begin
      n_bad++;
      $display("FAIL tob_latency: got T+%0d expected T+%0d", va, ROWS + 2);
    end
    n_cmp++;
    if (c !== ROWS || !sq) begin
      n_bad++;
      $display("FAIL tob_reads: got %0d reads seq=%0b expected %0d seq=1",
               c, sq, ROWS);
    end
    n_cmp++;
    if (!qo) begin
      n_bad++;
      $display("FAIL tob_qready: got query_ready=1 busy expected 0");
    end
  endtask

  task automatic test_tie();
    int c, va; bit sq, qo, so;
    logic [SW-1:0] e;
    clear_book(0);
    set_row(0, 2, 1, 105, 3);
    set_row(0, 6, 1, 105, 4);
    set_row(0, 3, 0, 200, 8);
    set_row(0, 8, 0, 200, 9);
    e = ref_vec(0);
    run_query(0, 1, 0, c, sq, va, qo, so);
    n_cmp++;
    if (cap[SW-4-PW -: QW] !== QW'(3) || cap !== e) begin
      n_bad++;
      $display("FAIL tie: got %h expected %h (bid_qty 3)", cap, e);
    end
  endtask

  task automatic test_empty();
    int c, va; bit sq, qo, so;
    clear_book(2);
    set_row(2, 5, 1, 500, 0);
    set_row(2, 7, 0, 50, 0);
    run_query(2, 0, 0, c, sq, va, qo, so);
    n_cmp++;
    if (cap !== '0) begin
      n_bad++;
      $display("FAIL empty: got %h expected 0", cap);
    end
    n_cmp++;
    if (va !== ROWS + 2 || c !== ROWS) begin
      n_bad++;
      $display("FAIL empty_timing: got T+%0d/%0d reads expected T+%0d/%0d",
               va, c, ROWS + 2, ROWS);
    end
  endtask

  task automatic test_bad_stock();
    int c, va; bit sq, qo, so;
    logic [SW-1:0] e;
    e = '0;
    e[SW-3] = 1'b1;
    run_query(3, 2, 0, c, sq, va, qo, so);
    n_cmp++;
    if (cap !== e) begin
      n_bad++;
      $display("FAIL bad_stock: got %h expected %h", cap, e);
    end
    n_cmp++;
    if (c !== 0 || va !== 1) begin
      n_bad++;
      $display("FAIL bad_timing: got %0d reads T+%0d expected 0 reads T+1",
               c, va);
    end
  endtask

  task automatic test_stall_ignore();
    int c, va; bit sq, qo, so, busy;
    logic [SW-1:0] e;
    clear_book(0);
    for (int r = 0; r < ROWS; r++)
      set_row(0, r, 1'($urandom_range(0, 1)), 90 + r, 1 + r);
    e = ref_vec(0);
    run_query(0, 5, 1, c, sq, va, qo, so);
    n_cmp++;
    if (cap !== e || !so) begin
      n_bad++;
      $display("FAIL stall: got %h stable=%0b expected %h stable=1",
               cap, so, e);
    end
    n_cmp++;
    if (!qo || c !== ROWS || !sq) begin
      n_bad++;
      $display("FAIL stall_ctrl: got qr_ok=%0b reads=%0d expected 1/%0d",
               qo, c, ROWS);
    end
    busy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!query_ready || rd_en || result_valid) busy = 1;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL ignore: got activity after handshake expected idle");
    end
  endtask

  task automatic test_reset_abort();
    bit act;
    int c, va; bit sq, qo, so;
    @(negedge clk);
    query_valid = 1'b1;
    query_stock = 2'd1;
    @(posedge clk);
    #1 query_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rd_en, result_valid, query_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL abort_scan: got rd_en/rv/qr=%b expected 001",
               {rd_en, result_valid, query_ready});
    end
    reset_n = 1'b1;
    act = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rd_en || result_valid) act = 1;
    end
    n_cmp++;
    if (act) begin
      n_bad++;
      $display("FAIL abort_quiet: got rd_en/result after reset expected none");
    end
    run_query(1, 3, 0, c, sq, va, qo, so);
    @(negedge clk);
    query_valid = 1'b1;
    query_stock = 2'd1;
    @(posedge clk);
    #1 query_valid = 1'b0;
    repeat (ROWS + 3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (result_valid !== 1'b0 || query_ready !== 1'b1 || snap() !== '0) begin
      n_bad++;
      $display("FAIL abort_done: got rv=%b qr=%b data=%h expected 0/1/0",
               result_valid, query_ready, snap());
    end
    reset_n = 1'b1;
  endtask

`ifdef BOOK_READER_SPREAD_EN
  task automatic test_spread();
    int c, va; bit sq, qo, so;
    clear_book(2);
    set_row(2, 1, 1, 110, 4);
    set_row(2, 4, 0, 108, 6);
    run_query(2, 0, 0, c, sq, va, qo, so);
    n_cmp++;
    if (cap[PW-1:0] !== '0 || cap[SW-1 -: 2] !== 2'b11) begin
      n_bad++;
      $display("FAIL spread_crossed: got %0d expected 0", cap[PW-1:0]);
    end
  endtask
`endif

  task automatic test_random();
    int c, va, stk, hold; bit sq, qo, so, sp;
    logic [SW-1:0] e;
    for (int it = 0; it < 30; it++) begin
      stk = (it % 7 == 6) ? 3 : $urandom_range(0, STOCKS - 1);
      if (stk < STOCKS) begin
        for (int r = 0; r < ROWS; r++) begin
          book[stk][r].v    = ($urandom_range(0, 3) != 0);
          book[stk][r].side = 1'($urandom_range(0, 1));
          book[stk][r].price = ($urandom_range(0, 3) == 0) ?
                               $urandom : PW'($urandom_range(95, 105));
          book[stk][r].qty  = ($urandom_range(0, 4) == 0) ?
                              '0 : QW'($urandom_range(1, 1000));
        end
      end
      e = ref_vec(stk);
      hold = $urandom_range(0, 3);
      sp = 1'($urandom_range(0, 1));
      run_query(stk, hold, sp, c, sq, va, qo, so);
      n_cmp++;
      if (cap !== e || !so) begin
        n_bad++;
        $display("FAIL rand_result[%0d]: got %h stable=%0b expected %h",
                 it, cap, so, e);
      end
      n_cmp++;
      if (va !== ((stk < STOCKS) ? ROWS + 2 : 1) ||
          c !== ((stk < STOCKS) ? ROWS : 0) || !sq || !qo) begin
        n_bad++;
        $display("FAIL rand_timing[%0d]: got T+%0d reads=%0d seq=%0b qr=%0b",
                 it, va, c, sq, qo);
      end
      @(negedge clk);
      n_cmp++;
      if (query_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_idle[%0d]: got query_ready=%b expected 1",
                 it, query_ready);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < STOCKS; s++) clear_book(s);
    test_reset();
    test_top_of_book();
    test_tie();
    test_empty();
    test_bad_stock();
    test_stall_ignore();
    test_reset_abort();
`ifdef BOOK_READER_SPREAD_EN
    test_spread();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/book_reader.md
BOOK_READER -- requirements
Module: book_reader

Interface
REQ-001 Parameter ROWS, default 10, number of entries per stock in the order book.
REQ-002 Parameter STOCKS, default 4, number of stock tables.
REQ-003 Parameter PRICE_W, default 32, price width; QTY_W, default 32, quantity width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 query_valid / query_ready  in / out  1 / 1  query handshake.
REQ-007 query_stock  in  2  stock index to scan.
REQ-008 rd_en  out  1  book read strobe.
REQ-009 rd_stock  out  2  stock index for the read.
REQ-010 rd_row  out  $clog2(ROWS)  row index for the read.
REQ-011 rd_entry_valid, rd_side, rd_price, rd_qty  in  1, 1, PRICE_W, QTY_W  book row data, one cycle after rd_en; rd_side 1 = buy, 0 = sell.
REQ-012 result_valid / result_ready  out / in  1 / 1  result handshake.
REQ-013 best_bid, best_ask  out  PRICE_W  top-of-book prices.
REQ-014 bid_qty, ask_qty  out  QTY_W  quantities of the chosen rows.
REQ-015 bid_found, ask_found, result_err  out  1 each  side present; query_stock >= STOCKS.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN, DRAIN, DONE; query_ready SHALL be 1 only in IDLE.
REQ-017 On a query handshake in IDLE at edge T with query_stock < STOCKS: go to SCAN, latch the stock, and clear the bid and ask accumulators and the found flags.
REQ-018 SCAN SHALL assert rd_en for exactly ROWS consecutive cycles, T+1..T+ROWS, with rd_row = 0..ROWS-1 and rd_stock = the latched stock; then go to DRAIN for one cycle, then DONE.
REQ-019 Each returned row SHALL be evaluated one cycle after its rd_en; rows with rd_entry_valid=0 or rd_qty=0 SHALL be skipped.
REQ-020 Buy rows: update the bid only if no bid is found yet or rd_price > best_bid (strict, so the lower row wins on a tie); the bid quantity follows the chosen row.
REQ-021 Sell rows: update the ask only if no ask is found yet or rd_price < best_ask (strict, lower row wins on a tie).
REQ-022 result_valid SHALL rise at cycle T+ROWS+2 and hold, with all result outputs stable, until result_ready=1; on that handshake go to IDLE.
REQ-023 If query_stock >= STOCKS: no reads; DONE at T+1 with result_err=1, found flags 0, prices and quantities 0.
REQ-024 When a side is not found, its price and quantity outputs SHALL be 0.
REQ-025 query_valid outside IDLE SHALL be ignored (not queued).
REQ-026 Price comparisons are unsigned and full-width, with no truncation.

Reset
REQ-027 reset_n=0 at any edge, including mid-SCAN or in DONE, SHALL go to IDLE and abort the scan with no result.
REQ-028 Reset values: query_ready=1 (once the block is in IDLE), rd_en=0, rd_stock=0, rd_row=0, result_valid=0, all prices, quantities and flags 0.

Configuration
REQ-029 Macro BOOK_READER_SPREAD_EN present: add output spread (PRICE_W) = best_ask - best_bid, registered with the result, valid with result_valid.
REQ-030 spread SHALL be 0 when either side is not found or when best_ask <= best_bid (crossed book).
REQ-031 Macro absent: there is no spread port or logic; all other behaviour is identical.

Structure
REQ-032 Package book_pkg SHALL hold the ROWS/STOCKS/PRICE_W/QTY_W defaults, the side encoding constants, and the reader FSM state enum.
REQ-033 One sub-module, book_best_cmp, SHALL hold the per-side accumulate/compare (instantiated twice, direction selected by parameter).

Verification
REQ-034 Stock 1, buy rows at prices 100/105/103 (qty 5/7/9), sell rows at 110/108 -> best_bid=105, bid_qty=7, best_ask=108, found=1/1, result_valid at T+12.
REQ-035 Two buy rows both at price 105 in rows 2 and 6 (qty 3/4) -> bid_qty=3 (lower row wins the tie).
REQ-036 Empty stock (all rd_entry_valid=0) -> bid_found=ask_found=0, all prices 0.
REQ-037 query_stock=3 with STOCKS=3 -> result_err=1, rd_en never asserted, result_valid at T+1.
REQ-038 result_ready held 0 for 5 cycles -> outputs stable and query_ready=0 throughout; reset_n=0 at cycle T+4 -> rd_en=0 and result_valid=0 on the next edge, and query_ready=1.
REQ-039 With BOOK_READER_SPREAD_EN: bid 105, ask 108 -> spread=3; bid 110, ask 108 -> spread=0.
